// File: rtl/ucsbece154b_bpred_gshare2w_pkg.sv
// Shared types and helpers for the gshare + 2-way BTB predictor.
// FSM states and counter init value live here.
package ucsbece154b_bpred_gshare2w_pkg;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  // weakly-not-taken: MSB clear, all lower bits set
  function automatic int unsigned ctr_wnt(
    input int unsigned cb
  );
    return (1 << (cb - 1)) - 1;
  endfunction

endpackage

// File: rtl/ucsbece154b_btb_2way.sv
// 2-way set-associative BTB with per-set LRU.
// Read is combinational; write/allocate and set clear are clocked.
module ucsbece154b_btb_2way
  import ucsbece154b_bpred_gshare2w_pkg::*;
#(
  parameter int unsigned NUM_SETS = 16,
  localparam int unsigned IDX = $clog2(NUM_SETS)
) (
  input  logic           clk,
  input  logic [31:0]    rd_pc,
  input  logic           rd_touch,
  output logic           rd_hit,
  output logic           rd_is_jump,
  output logic [31:0]    rd_target,
  input  logic           wr_en,
  input  logic [31:0]    wr_pc,
  input  logic [31:0]    wr_target,
  input  logic           wr_is_jump,
  input  logic           clr_en,
  input  logic [IDX-1:0] clr_set
);

  localparam int unsigned TW = 30 - IDX;

  logic [TW-1:0] tag_q [NUM_SETS][2];
  logic [31:0]   tgt_q [NUM_SETS][2];
  logic          jmp_q [NUM_SETS][2];
  logic [1:0]    vld_q [NUM_SETS];
  logic          lru_q [NUM_SETS];

  logic [IDX-1:0] rs;
  logic [TW-1:0]  rt;
  logic           rh0;
  logic           rh1;
  logic           rd_way;

  logic [IDX-1:0] ws;
  logic [TW-1:0]  wt;
  logic           wh0;
  logic           wh1;
  logic           wr_way;

  logic unused_lsb;
  assign unused_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rs = rd_pc[IDX+1:2];
  assign rt = rd_pc[31:IDX+2];
  assign rh0 = vld_q[rs][0] && (tag_q[rs][0] == rt);
  assign rh1 = vld_q[rs][1] && (tag_q[rs][1] == rt);

  assign rd_hit     = rh0 | rh1;
  assign rd_way     = ~rh0;
  assign rd_target  = tgt_q[rs][rd_way];
  assign rd_is_jump = jmp_q[rs][rd_way];

  assign ws = wr_pc[IDX+1:2];
  assign wt = wr_pc[31:IDX+2];
  assign wh0 = vld_q[ws][0] && (tag_q[ws][0] == wt);
  assign wh1 = vld_q[ws][1] && (tag_q[ws][1] == wt);

  // tag hit first, then first free way, then LRU victim
  always_comb begin
    wr_way = lru_q[ws];
    if (wh0)
      wr_way = 1'b0;
    else if (wh1)
      wr_way = 1'b1;
    else if (!vld_q[ws][0])
      wr_way = 1'b0;
    else if (!vld_q[ws][1])
      wr_way = 1'b1;
  end

  // write's LRU update is last so it wins over a same-set fetch hit
  always_ff @(posedge clk) begin
    if (clr_en) begin
      vld_q[clr_set] <= 2'b00;
      lru_q[clr_set] <= 1'b0;
    end else begin
      if (rd_touch && rd_hit)
        lru_q[rs] <= ~rd_way;
      if (wr_en) begin
        tag_q[ws][wr_way] <= wt;
        tgt_q[ws][wr_way] <= wr_target;
        jmp_q[ws][wr_way] <= wr_is_jump;
        vld_q[ws][wr_way] <= 1'b1;
        lru_q[ws]         <= ~wr_way;
      end
    end
  end

endmodule

// File: rtl/ucsbece154b_bpred_gshare2w.sv
// Fetch-stage gshare predictor with speculative GHR and 2-way BTB.
// Post-reset sweep initialises PHT and BTB before predicting.
module ucsbece154b_bpred_gshare2w
  import ucsbece154b_bpred_gshare2w_pkg::*;
#(
  parameter int unsigned NUM_BTB_SETS = 16,
  parameter int unsigned NUM_GHR_BITS = 6,
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset_ni,
  input  logic [31:0]             pc_i,
  input  logic                    predict_en_i,
  output logic                    ready_o,
  output logic                    pred_hit_o,
  output logic                    pred_taken_o,
  output logic [31:0]             pred_target_o,
  output logic [NUM_GHR_BITS-1:0] pred_ghr_o,
  input  logic                    upd_valid_i,
  input  logic [31:0]             upd_pc_i,
  input  logic [31:0]             upd_target_i,
  input  logic                    upd_is_branch_i,
  input  logic                    upd_is_jump_i,
  input  logic                    upd_taken_i,
  input  logic [NUM_GHR_BITS-1:0] upd_ghr_i,
  input  logic                    upd_mispredict_i
);

  localparam int unsigned G     = NUM_GHR_BITS;
  localparam int unsigned CB    = COUNTER_BITS;
  localparam int unsigned PHT_N = 2 ** G;
  localparam int unsigned IDX   = $clog2(NUM_BTB_SETS);
  localparam int unsigned SWEEP = max_u(PHT_N, NUM_BTB_SETS);
  localparam int unsigned CW    = $clog2(SWEEP);

  localparam logic [CB-1:0] CTR_WNT = CB'(ctr_wnt(CB));
  localparam logic [CB-1:0] CTR_MAX = '1;
  localparam logic [CB-1:0] CTR_MIN = '0;

  bp_state_e state_q;
  bp_state_e state_d;
  logic [CW-1:0] cnt_q;
  logic [G-1:0]  ghr_q;
  logic [CB-1:0] pht_q [PHT_N];

  logic          init;
  logic          run;
  logic          pht_init;
  logic          clr_en;

  logic [G-1:0]  rd_idx;
  logic [CB-1:0] rd_ctr;
  logic [G-1:0]  upd_idx;
  logic [CB-1:0] upd_ctr;
  logic [CB-1:0] upd_ctr_nx;
  logic          pht_wr;

  logic          btb_hit;
  logic          btb_is_jump;
  logic [31:0]   btb_target;
  logic          btb_wr;
  logic [31:0]   pc_plus4;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= BP_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (init)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    init    = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      BP_INIT: begin
        init = 1'b1;
        if (cnt_q == CW'(SWEEP - 1))
          state_d = BP_RUN;
      end
      BP_RUN: run = 1'b1;
      default: state_d = BP_INIT;
    endcase
  end

  assign ready_o  = run;
  assign pht_init = init && (32'(cnt_q) < PHT_N);
  assign clr_en   = init && (32'(cnt_q) < NUM_BTB_SETS);

  assign rd_idx  = pc_i[G+1:2] ^ ghr_q;
  assign rd_ctr  = pht_q[rd_idx];
  assign upd_idx = upd_pc_i[G+1:2] ^ upd_ghr_i;
  assign upd_ctr = pht_q[upd_idx];
  assign pht_wr  = run && upd_valid_i && upd_is_branch_i;

  // saturating counter, clamps at both ends
  always_comb begin
    upd_ctr_nx = upd_ctr;
    if (upd_taken_i && (upd_ctr != CTR_MAX))
      upd_ctr_nx = upd_ctr + 1'b1;
    else if (!upd_taken_i && (upd_ctr != CTR_MIN))
      upd_ctr_nx = upd_ctr - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (pht_init)
      pht_q[cnt_q[G-1:0]] <= CTR_WNT;
    else if (pht_wr)
      pht_q[upd_idx] <= upd_ctr_nx;
  end

  assign btb_wr = run && upd_valid_i &&
                  (upd_is_jump_i || (upd_is_branch_i && upd_taken_i));

  ucsbece154b_btb_2way #(
    .NUM_SETS (NUM_BTB_SETS)
  ) u_btb (
    .clk        (clk),
    .rd_pc      (pc_i),
    .rd_touch   (run && predict_en_i),
    .rd_hit     (btb_hit),
    .rd_is_jump (btb_is_jump),
    .rd_target  (btb_target),
    .wr_en      (btb_wr),
    .wr_pc      (upd_pc_i),
    .wr_target  (upd_target_i),
    .wr_is_jump (upd_is_jump_i),
    .clr_en     (clr_en),
    .clr_set    (cnt_q[IDX-1:0])
  );

  assign pc_plus4 = pc_i + PC_STEP;

  always_comb begin
    pred_hit_o    = 1'b0;
    pred_taken_o  = 1'b0;
    pred_target_o = pc_plus4;
    if (run && btb_hit) begin
      pred_hit_o   = 1'b1;
      pred_taken_o = btb_is_jump | rd_ctr[CB-1];
      if (pred_taken_o)
        pred_target_o = btb_target;
    end
  end

  assign pred_ghr_o = ghr_q;

  // repair from checkpoint beats speculative shift
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      ghr_q <= '0;
    end else if (run) begin
      if (upd_valid_i && upd_mispredict_i)
        ghr_q <= upd_is_branch_i ?
                 {upd_ghr_i[G-2:0], upd_taken_i} : upd_ghr_i;
      else if (predict_en_i && pred_hit_o && !btb_is_jump)
        ghr_q <= {ghr_q[G-2:0], pred_taken_o};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_ni && upd_valid_i)
      assert (!(upd_is_branch_i && upd_is_jump_i));
  end

endmodule

// File: tb/tb_ucsbece154b_bpred_gshare2w.sv
// Table-driven bench for the gshare 2-way predictor.
// Expected outputs are queued on drive and popped on sample.
module tb_ucsbece154b_bpred_gshare2w;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [31:0] pc_i;
  logic        predict_en_i;
  logic        ready_o;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic [5:0]  pred_ghr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_is_branch_i;
  logic        upd_is_jump_i;
  logic        upd_taken_i;
  logic [5:0]  upd_ghr_i;
  logic        upd_mispredict_i;

  ucsbece154b_bpred_gshare2w #(
    .NUM_BTB_SETS (16),
    .NUM_GHR_BITS (6),
    .COUNTER_BITS (2)
  ) dut (
    .clk              (clk),
    .reset_ni         (reset_ni),
    .pc_i             (pc_i),
    .predict_en_i     (predict_en_i),
    .ready_o          (ready_o),
    .pred_hit_o       (pred_hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_target_i     (upd_target_i),
    .upd_is_branch_i  (upd_is_branch_i),
    .upd_is_jump_i    (upd_is_jump_i),
    .upd_taken_i      (upd_taken_i),
    .upd_ghr_i        (upd_ghr_i),
    .upd_mispredict_i (upd_mispredict_i)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {
    U_NONE, U_BT, U_BN, U_JMP, U_BNM, U_JMM
  } ukind_e;

  typedef struct {
    logic [31:0] pc;
    logic        pen;
    ukind_e      k;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic [5:0]  ughr;
    logic        ehit;
    logic        etk;
    logic [31:0] etgt;
    logic [5:0]  eghr;
    logic        full;
  } vec_t;

  typedef struct {
    logic        ehit;
    logic        etk;
    logic [31:0] etgt;
    logic [5:0]  eghr;
    logic        full;
  } exp_t;

  vec_t vt[$];
  vec_t lt[$];
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mkv(
    input logic [31:0] pc, input logic pen, input ukind_e k,
    input logic [31:0] upc, input logic [31:0] utgt,
    input logic [5:0] ughr, input logic ehit, input logic etk,
    input logic [31:0] etgt, input logic [5:0] eghr,
    input logic full
  );
    vec_t v;
    v.pc = pc; v.pen = pen; v.k = k; v.upc = upc;
    v.utgt = utgt; v.ughr = ughr; v.ehit = ehit;
    v.etk = etk; v.etgt = etgt; v.eghr = eghr; v.full = full;
    return v;
  endfunction

  task automatic idle();
    predict_en_i = 1'b0;
    upd_valid_i = 1'b0;
    upd_pc_i = 32'h0;
    upd_target_i = 32'h0;
    upd_is_branch_i = 1'b0;
    upd_is_jump_i = 1'b0;
    upd_taken_i = 1'b0;
    upd_ghr_i = 6'd0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    idle();
    pc_i = v.pc;
    predict_en_i = v.pen;
    if (v.k != U_NONE) begin
      upd_valid_i = 1'b1;
      upd_pc_i = v.upc;
      upd_target_i = v.utgt;
      upd_ghr_i = v.ughr;
      upd_is_branch_i = (v.k == U_BT) || (v.k == U_BN) || (v.k == U_BNM);
      upd_is_jump_i = (v.k == U_JMP) || (v.k == U_JMM);
      upd_taken_i = (v.k == U_BT) || upd_is_jump_i;
      upd_mispredict_i = (v.k == U_BNM) || (v.k == U_JMM);
    end
    e.ehit = v.ehit; e.etk = v.etk; e.etgt = v.etgt;
    e.eghr = v.eghr; e.full = v.full;
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    n_vec++;
    if (pred_hit_o !== e.ehit ||
        (e.full && (pred_taken_o !== e.etk ||
                    pred_target_o !== e.etgt ||
                    pred_ghr_o !== e.eghr))) begin
      n_err++;
      $display("FAIL vec%0d: got hit=%b tk=%b tgt=%h ghr=%b want hit=%b tk=%b tgt=%h ghr=%b full=%b",
               id, pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o,
               e.ehit, e.etk, e.etgt, e.eghr, e.full);
    end
  endtask

  task automatic wait_ready(input string nm);
    int cyc;
    cyc = 0;
    while (!ready_o && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(nm, cyc, 64);
  endtask

  initial begin
    reset_ni = 1'b0;
    pc_i = 32'h100;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_ghr", {26'd0, pred_ghr_o}, 32'd0);
    chk("rst_tgt", pred_target_o, 32'h104);
    @(negedge clk);
    reset_ni = 1'b1;
    wait_ready("init_len");

    vt.push_back(mkv(32'h100, 1'b1, U_NONE, 0, 0, 6'd0, 1'b0, 1'b0, 32'h104, 6'd0, 1'b1));
    vt.push_back(mkv(32'h40, 1'b1, U_JMP, 32'h40, 32'h200, 6'd0, 1'b0, 1'b0, 32'h44, 6'd0, 1'b1));
    vt.push_back(mkv(32'h40, 1'b1, U_NONE, 0, 0, 6'd0, 1'b1, 1'b1, 32'h200, 6'd0, 1'b1));
    vt.push_back(mkv(32'h40, 1'b0, U_NONE, 0, 0, 6'd0, 1'b1, 1'b1, 32'h200, 6'd0, 1'b1));
    vt.push_back(mkv(32'h104, 1'b0, U_BT, 32'h104, 32'h300, 6'd0, 1'b0, 1'b0, 32'h108, 6'd0, 1'b1));
    for (int i = 0; i < 3; i++)
      vt.push_back(mkv(32'h104, 1'b0, U_BT, 32'h104, 32'h300, 6'd0, 1'b1, 1'b1, 32'h300, 6'd0, 1'b1));
    for (int i = 0; i < 2; i++)
      vt.push_back(mkv(32'h104, 1'b0, U_BN, 32'h104, 32'h300, 6'd0, 1'b1, 1'b1, 32'h300, 6'd0, 1'b1));
    for (int i = 0; i < 3; i++)
      vt.push_back(mkv(32'h104, 1'b0, U_BN, 32'h104, 32'h300, 6'd0, 1'b1, 1'b0, 32'h108, 6'd0, 1'b1));
    vt.push_back(mkv(32'h104, 1'b0, U_NONE, 0, 0, 6'd0, 1'b1, 1'b0, 32'h108, 6'd0, 1'b1));
    vt.push_back(mkv(32'h104, 1'b0, U_BT, 32'h104, 32'h300, 6'd0, 1'b1, 1'b0, 32'h108, 6'd0, 1'b1));
    vt.push_back(mkv(32'h104, 1'b0, U_BT, 32'h104, 32'h300, 6'd0, 1'b1, 1'b0, 32'h108, 6'd0, 1'b1));
    vt.push_back(mkv(32'h104, 1'b0, U_BT, 32'h104, 32'h300, 6'd1, 1'b1, 1'b1, 32'h300, 6'd0, 1'b1));
    vt.push_back(mkv(32'h104, 1'b0, U_BT, 32'h104, 32'h300, 6'd3, 1'b1, 1'b1, 32'h300, 6'd0, 1'b1));
    vt.push_back(mkv(32'h104, 1'b1, U_NONE, 0, 0, 6'd0, 1'b1, 1'b1, 32'h300, 6'd0, 1'b1));
    vt.push_back(mkv(32'h104, 1'b1, U_NONE, 0, 0, 6'd0, 1'b1, 1'b1, 32'h300, 6'd1, 1'b1));
    vt.push_back(mkv(32'h104, 1'b1, U_NONE, 0, 0, 6'd0, 1'b1, 1'b1, 32'h300, 6'd3, 1'b1));
    vt.push_back(mkv(32'h104, 1'b1, U_BNM, 32'h104, 32'h108, 6'd1, 1'b1, 1'b0, 32'h108, 6'd7, 1'b1));
    vt.push_back(mkv(32'h104, 1'b0, U_NONE, 0, 0, 6'd0, 1'b1, 1'b0, 32'h108, 6'd2, 1'b1));
    vt.push_back(mkv(32'h104, 1'b0, U_JMM, 32'h40, 32'h200, 6'd5, 1'b1, 1'b0, 32'h108, 6'd2, 1'b1));
    vt.push_back(mkv(32'h40, 1'b0, U_NONE, 0, 0, 6'd0, 1'b1, 1'b1, 32'h200, 6'd5, 1'b1));
    vt.push_back(mkv(32'h200, 1'b1, U_NONE, 0, 0, 6'd0, 1'b0, 1'b0, 32'h204, 6'd5, 1'b1));
    vt.push_back(mkv(32'h200, 1'b0, U_NONE, 0, 0, 6'd0, 1'b0, 1'b0, 32'h204, 6'd5, 1'b1));
    foreach (vt[i]) apply(vt[i], i);

    @(negedge clk);
    idle();
    pc_i = 32'h40;
    #2;
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    chk("mid_rst_ghr", {26'd0, pred_ghr_o}, 32'd0);
    chk("mid_rst_hit", {31'd0, pred_hit_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ni = 1'b1;
    wait_ready("reinit_len");

    lt.push_back(mkv(32'h40, 1'b0, U_NONE, 0, 0, 6'd0, 1'b0, 1'b0, 32'h44, 6'd0, 1'b1));
    lt.push_back(mkv(32'h104, 1'b0, U_NONE, 0, 0, 6'd0, 1'b0, 1'b0, 32'h108, 6'd0, 1'b1));
    lt.push_back(mkv(32'h0, 1'b0, U_BT, 32'h0, 32'h500, 6'd0, 1'b0, 1'b0, 0, 6'd0, 1'b0));
    lt.push_back(mkv(32'h0, 1'b0, U_BT, 32'h40, 32'h540, 6'd0, 1'b1, 1'b0, 0, 6'd0, 1'b0));
    lt.push_back(mkv(32'h0, 1'b1, U_NONE, 0, 0, 6'd0, 1'b1, 1'b0, 0, 6'd0, 1'b0));
    lt.push_back(mkv(32'h40, 1'b0, U_BT, 32'h80, 32'h580, 6'd0, 1'b1, 1'b0, 0, 6'd0, 1'b0));
    lt.push_back(mkv(32'h80, 1'b0, U_NONE, 0, 0, 6'd0, 1'b1, 1'b0, 0, 6'd0, 1'b0));
    lt.push_back(mkv(32'h40, 1'b0, U_NONE, 0, 0, 6'd0, 1'b0, 1'b0, 0, 6'd0, 1'b0));
    lt.push_back(mkv(32'h0, 1'b0, U_NONE, 0, 0, 6'd0, 1'b1, 1'b0, 0, 6'd0, 1'b0));
    foreach (lt[i]) apply(lt[i], 100 + i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_bpred_gshare2w.md
Name: ucsbece154b_bpred_gshare2w

Overview:
Parametrised next-generation fetch-stage branch predictor: gshare PHT with configurable-width saturating counters plus a 2-way set-associative BTB with per-set LRU replacement.
Adds three things over the current predictor: a speculative GHR with checkpoint repair on mispredict, a post-reset initialisation sweep, and an explicit execute-stage update interface.
Predicts in the fetch cycle; trained from the execute stage.

Parameters:
NUM_BTB_SETS, 16, BTB sets (power of 2, >=2); total entries = 2*NUM_BTB_SETS
NUM_GHR_BITS, 6, GHR width; PHT depth = 2^NUM_GHR_BITS (>=2)
COUNTER_BITS, 2, PHT saturating-counter width (>=2)

Ports:
clk  in  1  clock
reset_ni  in  1  reset
pc_i  in  32  fetch PC
predict_en_i  in  1  fetch advancing this cycle (not stalled)
ready_o  out  1  init sweep complete, predictions valid
pred_hit_o  out  1  BTB tag hit on pc_i
pred_taken_o  out  1  predicted taken
pred_target_o  out  32  next-PC prediction
pred_ghr_o  out  NUM_GHR_BITS  GHR checkpoint; travels down the pipe with the instruction
upd_valid_i  in  1  execute-stage update strobe
upd_pc_i  in  32  PC of resolved instruction
upd_target_i  in  32  resolved target
upd_is_branch_i  in  1  conditional branch
upd_is_jump_i  in  1  jal/jalr
upd_taken_i  in  1  actual outcome
upd_ghr_i  in  NUM_GHR_BITS  checkpoint returned from pred_ghr_o
upd_mispredict_i  in  1  direction or target mispredicted; fetch is being redirected

Interface note: one clock, clk; reset_ni is asynchronous and active-low.

Behaviour:
- Addressing: IDX = log2(NUM_BTB_SETS); set = pc[IDX+1:2]; tag = pc[31:IDX+2]. PHT index = pc[NUM_GHR_BITS+1:2] ^ GHR.
- Prediction is combinational, zero latency. Outputs by case:
  - hit on a jump: taken=1, target = stored target.
  - hit on a branch: taken = PHT counter MSB; target = stored target if taken, else pc_i+4.
  - miss: hit=0, taken=0, target = pc_i+4.
  - pred_ghr_o = current GHR.
- While ready_o=0: hit=0, taken=0, target=pc_i+4.
- FSM, INIT -> RUN:
  - Reset asserts async: state=INIT, sweep counter=0, GHR=0, ready_o=0.
  - INIT, each cycle: PHT[cnt] <= 2^(COUNTER_BITS-1)-1 (weakly not-taken); if cnt < NUM_BTB_SETS, clear both valid bits and the LRU bit of set cnt; cnt++.
  - INIT lasts exactly max(2^NUM_GHR_BITS, NUM_BTB_SETS) cycles, then RUN with ready_o=1.
  - Updates and predict_en_i are ignored in INIT. Reset mid-RUN restarts INIT.
- Speculative GHR, RUN only, priority order:
  1. upd_valid_i & upd_mispredict_i: GHR <= upd_is_branch_i ? {upd_ghr_i[G-2:0], upd_taken_i} : upd_ghr_i.
  2. Else predict_en_i & pred_hit_o & hit entry is a branch: GHR <= {GHR[G-2:0], pred_taken_o}.
  3. Else hold. Jumps never shift the GHR.
- PHT training: on upd_valid_i & upd_is_branch_i, counter at upd_pc_i[G+1:2]^upd_ghr_i saturating-increments if taken, else decrements. Clamps at 0 and 2^COUNTER_BITS-1; never wraps.
- BTB write: on upd_valid_i & (is_jump | (is_branch & taken)).
  - If the tag hits a way: overwrite that way's target and type.
  - Else allocate: first invalid way (way0 first), otherwise the LRU way.
  - After a write, LRU points to the other way.
  - Not-taken branches never allocate.
- LRU update on a fetch hit (predict_en_i & pred_hit_o): LRU <= non-hit way. If a write targets the same set in the same cycle, the write's LRU value wins.
- Same-cycle read and write to the same set: the read returns pre-write contents (no bypass).
- Same-cycle PHT read and write to one index: the read returns the old counter.
- upd_is_branch_i & upd_is_jump_i both high is illegal; assert in simulation.

Decomposition:
- ucsbece154b_defines.vh: add FSM state localparams BP_INIT/BP_RUN and the weakly-not-taken init macro. Opcode constants stay there.
- One sub-module, ucsbece154b_btb_2way: tag/target/type/valid arrays, LRU bits, hit and way-select logic, write/allocate, set clear port for the sweep.
- PHT, GHR and FSM stay in the top module.

Test Plan:
- Init sweep: G=6, sets=16; release reset_ni -> ready_o=0 for exactly 64 cycles, then 1; all PHT counters=01; pc_i=0x100 -> hit=0, target=0x104.
- Jump allocate: update jal pc=0x40 target=0x200 -> next cycle pc_i=0x40 gives hit=1, taken=1, target=0x200; GHR unchanged.
- Counter saturation: 4 taken updates at one PHT index -> counter 00/01 -> 11 and stays 11; prediction flips to taken after the 1st update from 01; 4 not-taken -> 00, no wrap.
- GHR repair: 3 speculative taken hits (GHR 000000 -> 000111), then mispredict with upd_ghr_i=000001, taken=0 -> GHR=000010 next cycle, overriding a simultaneous fetch hit.
- LRU replacement: taken branches at 0x000, 0x040, 0x080 (same set, sets=16), fetch-hit 0x000 before the third write -> 0x080 evicts 0x040; 0x000 still hits.
- Async reset mid-RUN: assert reset_ni low mid-cycle -> ready_o=0 immediately, GHR=0, sweep restarts; previously written entries miss afterwards.
